// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: load-use stalls,
// branch/jump flushes, data-memory wait-state freeze with timeout, stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_e,
  input  logic [4:0]  writereg_e,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        pcsrc_d,
  input  logic        jump_d,
  input  logic        mem_req_m,
  input  logic        mem_ready,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic        mem_timeout_err,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             err_q;
  logic [15:0]      stall_cnt;
  logic             loaduse;
  logic             memstall;

  assign loaduse = memread_e && (writereg_e != 5'd0) &&
                   ((writereg_e == rs_d) || (writereg_e == rt_d));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= '0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (next_state == ERR)
        err_q <= 1'b1;
      if (stall_f && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    memstall   = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (mem_req_m && !mem_ready) begin
            memstall   = 1'b1;
            next_state = MEM_WAIT;
            next_cnt   = CNT_W'(1);
          end else if (loaduse) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else if (pcsrc_d || jump_d) begin
            flush_d = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Stall holds through the ready cycle; the pipe advances on the next edge.
          memstall = 1'b1;
          if (mem_ready) begin
            next_state = RUN;
            next_cnt   = '0;
          end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
            next_state = ERR;
          end else begin
            next_cnt = cnt + CNT_W'(1);
          end
        end
        ERR: begin
          memstall = 1'b1;
        end
        default: begin
          next_state = RUN;
          next_cnt   = '0;
        end
      endcase
      if (memstall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end
    end
  end

  // Registered status is masked during reset so every output reads 0 that cycle.
  assign mem_timeout_err = err_q && !reset;
  assign stall_cycles    = reset ? '0 : stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against an access-level
// reference model (stalled cycles per memory access, sticky error, stall count).
module tb_pipe_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int unsigned CNT_W       = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread_e = 1'b0;
  logic [4:0]  writereg_e = '0;
  logic [4:0]  rs_d = '0;
  logic [4:0]  rt_d = '0;
  logic        pcsrc_d = 1'b0;
  logic        jump_d = 1'b0;
  logic        mem_req_m = 1'b0;
  logic        mem_ready = 1'b0;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w;
  logic        mem_timeout_err;
  logic [15:0] stall_cycles;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model: an access is "in progress" once the memory refuses the
  // request; waited counts the stalled cycles spent on it so far.
  bit          m_err;
  bit          m_in_access;
  int unsigned m_waited;
  int unsigned m_stalls;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .memread_e      (memread_e),
    .writereg_e     (writereg_e),
    .rs_d           (rs_d),
    .rt_d           (rt_d),
    .pcsrc_d        (pcsrc_d),
    .jump_d         (jump_d),
    .mem_req_m      (mem_req_m),
    .mem_ready      (mem_ready),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_w        (flush_w),
    .mem_timeout_err(mem_timeout_err),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle against the model, advance model.
  task automatic step(input bit rst, input bit mr, input logic [4:0] wr,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input bit pc, input bit jp, input bit rq, input bit rdy);
    bit mem_hold, hazard, redirect, exp_sf;
    logic [6:0] exp_ctl;
    reset = rst; memread_e = mr; writereg_e = wr; rs_d = rs; rt_d = rt;
    pcsrc_d = pc; jump_d = jp; mem_req_m = rq; mem_ready = rdy;
    @(negedge clk);
    mem_hold = !rst && (m_err || m_in_access || (rq && !rdy));
    hazard   = !rst && !mem_hold && mr && (wr != 0) && (wr == rs || wr == rt);
    redirect = !rst && !mem_hold && !hazard && (pc || jp);
    exp_sf   = mem_hold || hazard;
    exp_ctl  = {exp_sf, exp_sf, mem_hold, mem_hold, redirect, hazard, mem_hold};
    check("ctl", 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}), 32'(exp_ctl));
    check("err", 32'(mem_timeout_err), rst ? 32'd0 : 32'(m_err));
    check("stall_cycles", 32'(stall_cycles), rst ? 32'd0 : m_stalls);
    @(posedge clk);
    if (rst) begin
      m_err = 0; m_in_access = 0; m_waited = 0; m_stalls = 0;
    end else begin
      if (exp_sf && m_stalls < 65535) m_stalls++;
      if (!m_err) begin
        if (m_in_access) begin
          m_waited++;
          if (rdy) m_in_access = 0;
          else if (m_waited == MEM_TIMEOUT + 1) m_err = 1;
        end else if (rq && !rdy) begin
          m_in_access = 1;
          m_waited = 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    check("reset_cnt", 32'(stall_cycles), 32'd0);

    // Load-use on rs: one stall cycle
    step(0, 1, 5'd2, 5'd2, 5'd7, 0, 0, 0, 0);
    idle();
    check("lu_cnt", 32'(stall_cycles), 32'd1);
    // r0 destination never hazards
    step(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    check("r0_cnt", 32'(stall_cycles), 32'd1);
    // Branch alone flushes; with load-use the load-use wins
    step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    step(0, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0);
    // Single-cycle access: no stall
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    check("fast_mem_cnt", 32'(stall_cycles), 32'd2);

    // Three not-ready cycles then ready: four stalled cycles, hazards suppressed
    step(0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 1, 0);
    step(0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 1, 0);
    step(0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 1, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1);
    idle();
    check("wait_cnt", 32'(stall_cycles), 32'd6);

    // Timeout: ERR after 16 stalled cycles, sticky, cleared by reset
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    check("timeout_err", 32'(mem_timeout_err), 32'd1);
    check("timeout_cnt", 32'(stall_cycles), 32'd16);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    idle();
    check("err_sticky", 32'(mem_timeout_err), 32'd1);
    do_reset();
    check("err_cleared", 32'(mem_timeout_err), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) == 0, $urandom % 2,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom % 4) == 0, ($urandom % 8) == 0,
           ($urandom % 3) == 0, ($urandom % 2) == 0);
    end

    // Saturation: park in ERR long enough to overflow the counter
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    for (int i = 0; i < 65600; i++) idle();
    check("sat_cnt", 32'(stall_cycles), 32'h0000_FFFF);

    // Reset in the middle of a memory wait
    do_reset();
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle();
    check("midwait_reset_cnt", 32'(stall_cycles), 32'd0);
    check("midwait_reset_stall", 32'(stall_f), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
